// File: rtl/stack_ptr_10bit.sv
// ---------------------------------------------------------------------------
// stack_ptr_10bit
// Stack-pointer unit for a byte-addressed, word-aligned, downward-growing
// data stack. Produces push write address / pop read address strobes,
// keeps depth/full/empty status and sticky overflow/underflow flags.
//
// Ports:
//   clk         system clock, rising edge
//   rst_n       asynchronous active-low reset
//   push, pop   word push / pop requests for this cycle
//   load_en     load SP from load_value (has priority over push/pop)
//   load_value  new SP value (bit 0 is ignored)
//   clr_err     clears overflow and underflow at the next edge
//   sp          registered stack pointer, points at top-of-stack word
//   wr_addr     combinational push write address
//   wr_en       combinational, push accepted this cycle
//   rd_addr     combinational pop read address (always equal to sp)
//   rd_en       combinational, pop accepted this cycle
//   depth       registered, (STACK_TOP - sp) / STEP
//   empty       registered, sp == STACK_TOP
//   full        registered, sp == STACK_LIMIT
//   overflow    sticky, push refused when full or load below STACK_LIMIT
//   underflow   sticky, pop refused when empty or load above STACK_TOP
// ---------------------------------------------------------------------------
module stack_ptr_10bit #(
  parameter int                ADDR_W      = 10,
  parameter logic [ADDR_W-1:0] STACK_TOP   = 10'h3FE,
  parameter logic [ADDR_W-1:0] STACK_LIMIT = 10'h200,
  parameter int                STEP        = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic              pop,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_value,
  input  logic              clr_err,
  output logic [ADDR_W-1:0] sp,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              wr_en,
  output logic [ADDR_W-1:0] rd_addr,
  output logic              rd_en,
  output logic [ADDR_W-2:0] depth,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  output logic              underflow
);

  localparam logic [ADDR_W-1:0] STEP_V = ADDR_W'(STEP);

  logic [ADDR_W-1:0] load_v;
  logic [ADDR_W-1:0] sp_next;
  logic [ADDR_W-1:0] depth_diff;
  logic              wr_ok;
  logic              rd_ok;
  logic              set_ovf;
  logic              set_unf;

  // Word alignment: the load target always has bit 0 cleared.
  assign load_v     = load_value & ~ADDR_W'(1);
  assign depth_diff = STACK_TOP - sp_next;

  always_comb begin
    wr_ok   = 1'b0;
    rd_ok   = 1'b0;
    set_ovf = 1'b0;
    set_unf = 1'b0;
    sp_next = sp;
    wr_addr = sp - STEP_V;
    rd_addr = sp;

    if (load_en) begin
      if (load_v < STACK_LIMIT) begin
        set_ovf = 1'b1;
      end else if (load_v > STACK_TOP) begin
        set_unf = 1'b1;
      end else begin
        sp_next = load_v;
      end
    end else if (push && pop) begin
      if (!empty) begin
        // Replace top of stack in place; a full stack does not block this.
        wr_ok   = 1'b1;
        rd_ok   = 1'b1;
        wr_addr = sp;
      end else begin
        // Empty cannot also be full, so the push always fits here.
        wr_ok   = 1'b1;
        sp_next = sp - STEP_V;
        set_unf = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        wr_ok   = 1'b1;
        sp_next = sp - STEP_V;
      end else begin
        set_ovf = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        rd_ok   = 1'b1;
        sp_next = sp + STEP_V;
      end else begin
        set_unf = 1'b1;
      end
    end
  end

  // Strobes are forced low while reset is asserted so a request held
  // through reset never reaches memory.
  assign wr_en = wr_ok & rst_n;
  assign rd_en = rd_ok & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sp        <= STACK_TOP;
      depth     <= '0;
      empty     <= 1'b1;
      full      <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      sp        <= sp_next;
      depth     <= (ADDR_W-1)'(depth_diff / STEP_V);
      empty     <= (sp_next == STACK_TOP);
      full      <= (sp_next == STACK_LIMIT);
      // A fresh error wins over clr_err; the other flag still clears.
      overflow  <= set_ovf | (overflow  & ~clr_err);
      underflow <= set_unf | (underflow & ~clr_err);
    end
  end

endmodule
